pc_source_ctrl: RTL

- Driver side of the PC-source select path: decides which next-PC candidate is loaded and when the PC register is written.
- Produces the 3-bit select consumed by the PC-source mux and the PC write strobe.
- Owns the EPC register and sequences exception entry: save EPC, read the handler address byte from the vector table, load PC.
- Sits between the main control FSM (request pulses in) and the PC/EPC datapath.

---
 rtl/pc_source_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_source_ctrl.sv
// -----------------------------------------------------------------------------
// pc_source_ctrl
//
// Purpose:
//   Drives the PC-source select path. Decides which next-PC candidate the
//   PC-source mux forwards and when the PC register is written. Owns the EPC
//   register and sequences exception entry: save EPC, fetch the handler
//   address byte from the vector table, then load the PC from that data.
//
// Optional feature (macro PCSRC_EXC_CNT_EN):
//   When defined, adds output exc_count[7:0], a saturating count of exception
//   entries. When undefined, the port and counter are absent.
//
// Parameters:
//   MEM_LAT   memory read wait cycles before vector data is valid (1..15)
//   VEC_BASE  byte address of the cause-0 vector entry (cause n at +n)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   fetch_req     in   pulse: advance PC to PC+4
//   resolve_req   in   pulse: apply transfer selected by resolve_kind
//   resolve_kind  in   0 branch, 1 jump, 2 jump-register, 3 exception return
//   br_cond       in   branch condition, sampled with resolve_req
//   exc_opcode    in   invalid-opcode exception pulse
//   exc_ovf       in   overflow exception pulse
//   exc_div0      in   divide-by-zero exception pulse
//   pc_in         in   current PC, used for EPC capture
//   muxpcsource   out  0 vector data, 1 ALU result, 2 ALUOut, 3 jump, 4 EPC
//   pc_write      out  PC register write enable
//   epc_write     out  pulse when EPC is updated
//   epc_out       out  EPC register contents
//   cause         out  latched exception code (0 opcode, 1 ovf, 2 div0)
//   exc_addr      out  vector table read address
//   exc_mem_rd    out  vector table read request
//   busy          out  exception sequence in progress
//   exc_count     out  (PCSRC_EXC_CNT_EN only) saturating exception count
// -----------------------------------------------------------------------------
module pc_source_ctrl #(
   parameter int unsigned MEM_LAT  = 2,
   parameter logic [31:0] VEC_BASE = 32'd253
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic        resolve_req,
   input  logic [1:0]  resolve_kind,
   input  logic        br_cond,
   input  logic        exc_opcode,
   input  logic        exc_ovf,
   input  logic        exc_div0,
   input  logic [31:0] pc_in,
   output logic [2:0]  muxpcsource,
   output logic        pc_write,
   output logic        epc_write,
   output logic [31:0] epc_out,
   output logic [1:0]  cause,
   output logic [31:0] exc_addr,
   output logic        exc_mem_rd,
`ifdef PCSRC_EXC_CNT_EN
   output logic [7:0]  exc_count,
`endif
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXC_SAVE = 2'd1,
      EXC_WAIT = 2'd2,
      EXC_LOAD = 2'd3
   } state_t;

   state_t      state_r;
   logic [3:0]  wait_cnt_r;
   logic        exc_any_s;
   logic [1:0]  exc_sel_s;

   // Fixed-priority pick among simultaneous exceptions: opcode > ovf > div0.
   function automatic logic [1:0] exc_winner(input logic opc, input logic ovf);
      logic [1:0] code;
      if (opc) begin
         code = 2'd0;
      end else if (ovf) begin
         code = 2'd1;
      end else begin
         code = 2'd2;
      end
      return code;
   endfunction

   assign exc_any_s = exc_opcode | exc_ovf | exc_div0;
   assign exc_sel_s = exc_winner(exc_opcode, exc_ovf);

   // Control FSM: request arbitration, exception sequencing and all outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         wait_cnt_r  <= 4'd0;
         muxpcsource <= 3'd1;
         pc_write    <= 1'b0;
         epc_write   <= 1'b0;
         epc_out     <= 32'd0;
         cause       <= 2'd0;
         exc_addr    <= 32'd0;
         exc_mem_rd  <= 1'b0;
         busy        <= 1'b0;
`ifdef PCSRC_EXC_CNT_EN
         exc_count   <= 8'd0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               // Only IDLE arbitrates; requests seen in any other state are dropped.
               if (exc_any_s) begin
                  state_r    <= EXC_SAVE;
                  cause      <= exc_sel_s;
                  epc_out    <= pc_in - 32'd4;   // wraps mod 2^32
                  epc_write  <= 1'b1;
                  exc_addr   <= VEC_BASE + {30'd0, exc_sel_s};
                  exc_mem_rd <= 1'b1;
                  busy       <= 1'b1;
                  pc_write   <= 1'b0;
`ifdef PCSRC_EXC_CNT_EN
                  if (exc_count != 8'hFF) begin
                     exc_count <= exc_count + 8'd1;
                  end else begin
                     exc_count <= exc_count;
                  end
`endif
               end else if (resolve_req) begin
                  epc_write <= 1'b0;
                  case (resolve_kind)
                     2'd0: begin
                        // Not-taken branch leaves the select untouched.
                        if (br_cond) begin
                           muxpcsource <= 3'd2;
                           pc_write    <= 1'b1;
                        end else begin
                           pc_write    <= 1'b0;
                        end
                     end
                     2'd1: begin
                        muxpcsource <= 3'd3;
                        pc_write    <= 1'b1;
                     end
                     2'd2: begin
                        muxpcsource <= 3'd1;
                        pc_write    <= 1'b1;
                     end
                     2'd3: begin
                        muxpcsource <= 3'd4;
                        pc_write    <= 1'b1;
                     end
                     default: begin
                        pc_write    <= 1'b0;
                     end
                  endcase
               end else if (fetch_req) begin
                  muxpcsource <= 3'd1;
                  pc_write    <= 1'b1;
                  epc_write   <= 1'b0;
               end else begin
                  pc_write    <= 1'b0;
                  epc_write   <= 1'b0;
               end
            end

            EXC_SAVE: begin
               // Counter holds the remaining wait cycles after this one.
               state_r    <= EXC_WAIT;
               wait_cnt_r <= 4'(MEM_LAT - 1);
               epc_write  <= 1'b0;
               pc_write   <= 1'b0;
            end

            EXC_WAIT: begin
               if (wait_cnt_r == 4'd0) begin
                  state_r     <= EXC_LOAD;
                  muxpcsource <= 3'd0;
                  pc_write    <= 1'b1;
                  exc_mem_rd  <= 1'b0;
               end else begin
                  wait_cnt_r  <= wait_cnt_r - 4'd1;
               end
            end

            EXC_LOAD: begin
               state_r  <= IDLE;
               pc_write <= 1'b0;
               busy     <= 1'b0;
            end

            default: begin
               state_r    <= IDLE;
               pc_write   <= 1'b0;
               epc_write  <= 1'b0;
               exc_mem_rd <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
